// File: rtl/fmps_trip_evaluate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fmps_trip_evaluate_pkg
// Brief   : Shared constants, field positions and FSM encoding for the FMPS
//           trip evaluator.
// Revision: 1.0 - initial release
// ============================================================================
package fmps_trip_evaluate_pkg;

  localparam int c_FMPS_WORD_FAULT_BIT = 31;

  // GPIO_OUT control word layout
  localparam int c_GPIO_MASK_LSB    = 16;
  localparam int c_GPIO_MISSING_BIT = 29;
  localparam int c_GPIO_ENABLE_BIT  = 30;
  localparam int c_GPIO_CLEAR_BIT   = 31;

  // csr status word layout
  localparam int c_CSR_BUSY_BIT      = 31;
  localparam int c_CSR_LATCHED_BIT   = 30;
  localparam int c_CSR_TIMEOUT_BIT   = 29;
  localparam int c_CSR_ENABLE_BIT    = 28;
  localparam int c_CSR_MISSING_BIT   = 27;
  localparam int c_CSR_SEQNO_LSB     = 16;
  localparam int c_CSR_TRIPCOUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] fit8(input logic [31:0] value);
    return value[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmps_trip_evaluate_if.sv
`default_nettype none
// ============================================================================
// Module  : fmps_trip_evaluate_if
// Brief   : Readout port between the FMPS link gatherer (master) and the trip
//           evaluator (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface fmps_trip_evaluate_if #(
  parameter int INDEX_WIDTH = 5
);

  logic                          readoutValid;
  logic                          sysTimeoutStrobe;
  logic [(1<<INDEX_WIDTH)-1:0]   rxBitmap;
  logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress;
  logic [31:0]                   fmpsReadout;

  modport master (
    output readoutValid,
    output sysTimeoutStrobe,
    output rxBitmap,
    output fmpsReadout,
    input  fmpsReadoutAddress
  );

  modport slave (
    input  readoutValid,
    input  sysTimeoutStrobe,
    input  rxBitmap,
    input  fmpsReadout,
    output fmpsReadoutAddress
  );

endinterface
`default_nettype wire

// File: rtl/fmps_trip_evaluate.sv
`default_nettype none
// ============================================================================
// Module  : fmps_trip_evaluate
// Brief   : Scans every FMPS slot after each gatherer readout, evaluates trip
//           flags against the CSR mask and drives the mitigation trip strobe.
// Revision: 1.0 - initial release
// ============================================================================
module fmps_trip_evaluate
  import fmps_trip_evaluate_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int TRIP_WIDTH  = 8,
  parameter int SEQNO_WIDTH = 8
) (
  input  wire logic                          sysClk,
  input  wire logic                          sysReset_n,
  input  wire logic                          csrStrobe,
  input  wire logic [31:0]                   GPIO_OUT,
  output logic [31:0]                        csr,
  fmps_trip_evaluate_if.slave                gath,
  output logic                               tripStrobe,
  output logic [(1<<INDEX_WIDTH)-1:0]        tripBitmap,
  output logic                               tripLatched,
  output logic                               scanDone
);

  localparam int c_SLOTS = 1 << INDEX_WIDTH;
  localparam int c_CW    = INDEX_WIDTH + 1;

  state_t                   r_state;
  logic [c_CW-1:0]          r_fmpsCount;
  logic [7:0]               r_tripMask;
  logic                     r_missingIsTrip;
  logic                     r_enable;
  logic                     r_readoutValidD;
  logic [INDEX_WIDTH-1:0]   r_addr;
  logic [INDEX_WIDTH-1:0]   r_addrD;
  logic                     r_validD;
  logic [c_SLOTS-1:0]       r_accBitmap;
  logic [c_CW-1:0]          r_accCount;
  logic [c_CW-1:0]          r_tripCountLast;
  logic [SEQNO_WIDTH-1:0]   r_seqno;
  logic                     r_toPending;
  logic                     r_timeoutTrip;

  logic                     w_startEdge;
  logic [c_CW-1:0]          w_gpioCount;
  logic [c_CW-1:0]          w_countSat;
  logic                     w_lastAddr;
  logic                     w_slotTrip;
  logic                     w_timeoutArmed;
  logic                     w_toPend;
  logic                     w_idleTimeout;
  logic                     w_doneTimeout;
  logic                     w_doneTrip;
  logic                     w_setLatch;
  logic                     w_setTimeout;
  logic                     w_clear;
  logic                     w_unused;

  assign w_startEdge = gath.readoutValid & ~r_readoutValidD;
  assign w_gpioCount = GPIO_OUT[INDEX_WIDTH:0];
  assign w_countSat  = (w_gpioCount > c_CW'(c_SLOTS)) ? c_CW'(c_SLOTS) : w_gpioCount;

  // Relational compare keeps the scan terminating if fmpsCount shrinks mid-scan.
  assign w_lastAddr  = (r_fmpsCount <= c_CW'(1)) ||
                       ({1'b0, r_addr} >= (r_fmpsCount - c_CW'(1)));

  assign w_slotTrip  = (|(gath.fmpsReadout[TRIP_WIDTH-1:0] & r_tripMask[TRIP_WIDTH-1:0]))
                     | gath.fmpsReadout[c_FMPS_WORD_FAULT_BIT]
                     | (r_missingIsTrip & ~gath.rxBitmap[r_addrD]);

  assign w_timeoutArmed = r_enable & r_missingIsTrip;
  assign w_toPend       = r_toPending | gath.sysTimeoutStrobe;
  assign w_idleTimeout  = (r_state == ST_IDLE) & gath.sysTimeoutStrobe & w_timeoutArmed;
  assign w_doneTimeout  = (r_state == ST_DONE) & w_toPend & w_timeoutArmed;
  assign w_doneTrip     = (r_state == ST_DONE) & r_enable & ((|r_accBitmap) | w_doneTimeout);
  assign w_setLatch     = w_doneTrip | w_idleTimeout;
  assign w_setTimeout   = w_idleTimeout | w_doneTimeout;
  assign w_clear        = csrStrobe & GPIO_OUT[c_GPIO_CLEAR_BIT];

  assign gath.fmpsReadoutAddress = r_addr;

  assign csr = {(r_state != ST_IDLE), tripLatched, r_timeoutTrip, r_enable, r_missingIsTrip,
                3'b000, fit8(32'(r_seqno)), fit8(32'(r_tripCountLast)), fit8(32'(r_fmpsCount))};

  assign w_unused = &{1'b0, GPIO_OUT, gath.fmpsReadout, r_tripMask};

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_state         <= ST_IDLE;
      r_fmpsCount     <= '0;
      r_tripMask      <= '0;
      r_missingIsTrip <= 1'b0;
      r_enable        <= 1'b0;
      r_readoutValidD <= 1'b0;
      r_addr          <= '0;
      r_addrD         <= '0;
      r_validD        <= 1'b0;
      r_accBitmap     <= '0;
      r_accCount      <= '0;
      r_tripCountLast <= '0;
      r_seqno         <= '0;
      r_toPending     <= 1'b0;
      r_timeoutTrip   <= 1'b0;
      tripStrobe      <= 1'b0;
      tripBitmap      <= '0;
      tripLatched     <= 1'b0;
      scanDone        <= 1'b0;
    end else begin
      r_readoutValidD <= gath.readoutValid;
      tripStrobe      <= 1'b0;
      scanDone        <= 1'b0;
      r_validD        <= 1'b0;

      if (csrStrobe) begin
        r_fmpsCount     <= w_countSat;
        r_tripMask      <= GPIO_OUT[c_GPIO_MASK_LSB +: 8];
        r_missingIsTrip <= GPIO_OUT[c_GPIO_MISSING_BIT];
        r_enable        <= GPIO_OUT[c_GPIO_ENABLE_BIT];
      end

      // A trip in the same cycle as a clear request wins.
      if (w_setLatch) begin
        tripLatched <= 1'b1;
      end else if (w_clear) begin
        tripLatched <= 1'b0;
      end
      if (w_setTimeout) begin
        r_timeoutTrip <= 1'b1;
      end else if (w_clear) begin
        r_timeoutTrip <= 1'b0;
      end

      if (r_validD) begin
        r_accBitmap[r_addrD] <= w_slotTrip;
        r_accCount           <= r_accCount + c_CW'(w_slotTrip);
      end

      case (r_state)
        ST_IDLE: begin
          r_addr      <= '0;
          r_toPending <= 1'b0;
          tripStrobe  <= w_idleTimeout;
          if (w_startEdge) begin
            r_accBitmap <= '0;
            r_accCount  <= '0;
            // An empty scan still passes through DRAIN so every scan takes fmpsCount+2 cycles.
            r_state     <= (r_fmpsCount == '0) ? ST_DRAIN : ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_validD    <= 1'b1;
          r_addrD     <= r_addr;
          r_toPending <= w_toPend;
          if (w_lastAddr) begin
            r_addr  <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_addr  <= r_addr + INDEX_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          r_toPending <= w_toPend;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          tripBitmap      <= r_accBitmap;
          r_tripCountLast <= r_accCount;
          r_seqno         <= r_seqno + SEQNO_WIDTH'(1);
          scanDone        <= 1'b1;
          tripStrobe      <= w_doneTrip;
          r_toPending     <= 1'b0;
          r_state         <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmps_trip_evaluate.sv
`default_nettype none
// ============================================================================
// Module  : tb_fmps_trip_evaluate
// Brief   : Directed self-checking bench for the FMPS trip evaluator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fmps_trip_evaluate;

  logic        sysClk;
  logic        sysReset_n;
  logic        csrStrobe;
  logic [31:0] GPIO_OUT;
  logic [31:0] csr;
  logic        tripStrobe;
  logic [31:0] tripBitmap;
  logic        tripLatched;
  logic        scanDone;

  int checks;
  int errors;

  logic [31:0] mem [32];

  fmps_trip_evaluate_if #(.INDEX_WIDTH(5)) gath ();

  fmps_trip_evaluate #(
    .INDEX_WIDTH(5),
    .TRIP_WIDTH (8),
    .SEQNO_WIDTH(8)
  ) dut (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .csrStrobe  (csrStrobe),
    .GPIO_OUT   (GPIO_OUT),
    .csr        (csr),
    .gath       (gath),
    .tripStrobe (tripStrobe),
    .tripBitmap (tripBitmap),
    .tripLatched(tripLatched),
    .scanDone   (scanDone)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // Gatherer model: readout data one cycle after the address.
  always @(posedge sysClk) gath.fmpsReadout <= mem[gath.fmpsReadoutAddress];

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic csr_write(input logic [5:0] cnt, input logic [7:0] mask,
                           input logic missing, input logic en, input logic clr);
    GPIO_OUT = {clr, en, missing, 5'b0, mask, 10'b0, cnt};
    csrStrobe = 1'b1;
    @(negedge sysClk);
    csrStrobe = 1'b0;
    GPIO_OUT  = 32'h0;
  endtask

  task automatic do_scan(input int toAt, input int glitchAt, output int lat,
                         output int nStrobe, output int firstStrobe, output int nDone);
    lat = -1; nStrobe = 0; firstStrobe = -1; nDone = 0;
    gath.readoutValid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge sysClk);
      if (tripStrobe) begin
        nStrobe++;
        if (firstStrobe < 0) firstStrobe = k;
      end
      if (scanDone) begin
        nDone++;
        if (lat < 0) lat = k;
      end
      gath.sysTimeoutStrobe = (k == toAt);
      if (k == glitchAt) gath.readoutValid = 1'b0;
      else if (k == glitchAt + 1) gath.readoutValid = 1'b1;
      if (lat >= 0 && k >= lat + 8) break;
    end
    gath.readoutValid     = 1'b0;
    gath.sysTimeoutStrobe = 1'b0;
    @(negedge sysClk);
  endtask

  task automatic test_reset();
    sysReset_n = 1'b0;
    repeat (2) @(negedge sysClk);
    checks++;
    if (csr !== 32'h0 || tripBitmap !== 32'h0 || tripStrobe !== 1'b0 ||
        tripLatched !== 1'b0 || scanDone !== 1'b0 || gath.fmpsReadoutAddress !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: csr=%h bitmap=%h strobe=%b latched=%b done=%b addr=%0d, want all 0",
               csr, tripBitmap, tripStrobe, tripLatched, scanDone, gath.fmpsReadoutAddress);
    end
    sysReset_n = 1'b1;
    @(negedge sysClk);
  endtask

  task automatic test_basic_mask();
    int lat, ns, fs, nd;
    clear_mem();
    mem[2] = 32'h0000_0001;
    gath.rxBitmap = 32'h0000_000F;
    csr_write(6'd4, 8'h01, 1'b0, 1'b1, 1'b0);
    do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d, want 6", lat); end
    checks++;
    if (ns !== 1) begin errors++; $display("FAIL basic_strobes: got %0d, want 1", ns); end
    checks++;
    if (tripBitmap !== 32'h4) begin errors++; $display("FAIL basic_bitmap: got %h, want 4", tripBitmap); end
    checks++;
    if (csr !== 32'h5001_0104) begin errors++; $display("FAIL basic_csr: got %h, want 50010104", csr); end
  endtask

  task automatic test_fault_and_clear();
    int lat, ns, fs, nd;
    clear_mem();
    mem[1] = 32'h8000_0000;
    gath.rxBitmap = 32'h0000_000F;
    csr_write(6'd4, 8'h00, 1'b0, 1'b1, 1'b1);
    checks++;
    if (tripLatched !== 1'b0) begin errors++; $display("FAIL fault_preclear: latched=%b, want 0", tripLatched); end
    do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (tripBitmap !== 32'h2 || tripLatched !== 1'b1 || ns !== 1) begin
      errors++;
      $display("FAIL fault_scan: bitmap=%h latched=%b strobes=%0d, want 2/1/1", tripBitmap, tripLatched, ns);
    end
    csr_write(6'd4, 8'h00, 1'b0, 1'b1, 1'b1);
    checks++;
    if (tripLatched !== 1'b0 || csr[30] !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: latched=%b csr30=%b, want 0/0", tripLatched, csr[30]);
    end
  endtask

  task automatic test_missing();
    int lat, ns, fs, nd;
    clear_mem();
    gath.rxBitmap = 32'h0000_000B;
    csr_write(6'd4, 8'hFF, 1'b1, 1'b1, 1'b1);
    do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (tripBitmap !== 32'h4 || ns !== 1 || csr[15:8] !== 8'd1) begin
      errors++;
      $display("FAIL missing_on: bitmap=%h strobes=%0d count=%0d, want 4/1/1", tripBitmap, ns, csr[15:8]);
    end
    // Second scan also re-raises readoutValid mid-scan, which must not restart it.
    csr_write(6'd4, 8'hFF, 1'b0, 1'b1, 1'b1);
    do_scan(-1, 1, lat, ns, fs, nd);
    checks++;
    if (ns !== 0 || nd !== 1 || lat !== 6 || tripBitmap !== 32'h0) begin
      errors++;
      $display("FAIL missing_off: strobes=%0d dones=%0d lat=%0d bitmap=%h, want 0/1/6/0", ns, nd, lat, tripBitmap);
    end
  endtask

  task automatic test_timeout();
    int lat, ns, fs, nd;
    clear_mem();
    gath.rxBitmap = 32'h0000_000F;
    csr_write(6'd4, 8'h00, 1'b1, 1'b1, 1'b1);
    gath.sysTimeoutStrobe = 1'b1;
    @(negedge sysClk);
    gath.sysTimeoutStrobe = 1'b0;
    checks++;
    if (tripStrobe !== 1'b1 || csr[29] !== 1'b1 || tripLatched !== 1'b1 || tripBitmap !== 32'h0) begin
      errors++;
      $display("FAIL timeout_idle: strobe=%b csr29=%b latched=%b bitmap=%h, want 1/1/1/0",
               tripStrobe, csr[29], tripLatched, tripBitmap);
    end
    @(negedge sysClk);
    checks++;
    if (tripStrobe !== 1'b0) begin errors++; $display("FAIL timeout_pulse: strobe=%b, want 0", tripStrobe); end
    csr_write(6'd4, 8'h00, 1'b1, 1'b1, 1'b1);
    do_scan(2, -1, lat, ns, fs, nd);
    checks++;
    if (ns !== 1 || fs !== lat || lat !== 6 || csr[29] !== 1'b1 || tripBitmap !== 32'h0) begin
      errors++;
      $display("FAIL timeout_scan: strobes=%0d at=%0d lat=%0d csr29=%b bitmap=%h, want 1/6/6/1/0",
               ns, fs, lat, csr[29], tripBitmap);
    end
  endtask

  task automatic test_zero_wrap_saturate();
    int lat, ns, fs, nd;
    test_reset();
    clear_mem();
    gath.rxBitmap = 32'hFFFF_FFFF;
    csr_write(6'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (lat !== 2 || ns !== 0) begin errors++; $display("FAIL zero_count: lat=%0d strobes=%0d, want 2/0", lat, ns); end
    for (int i = 0; i < 254; i++) do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (csr[23:16] !== 8'd255) begin errors++; $display("FAIL seqno_255: got %0d, want 255", csr[23:16]); end
    do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (csr[23:16] !== 8'd0) begin errors++; $display("FAIL seqno_wrap: got %0d, want 0", csr[23:16]); end
    mem[31] = 32'h8000_0000;
    csr_write(6'd63, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (csr[7:0] !== 8'd32) begin errors++; $display("FAIL count_saturate: got %0d, want 32", csr[7:0]); end
    do_scan(-1, -1, lat, ns, fs, nd);
    checks++;
    if (lat !== 34 || tripBitmap !== 32'h8000_0000 || ns !== 1) begin
      errors++;
      $display("FAIL full_scan: lat=%0d bitmap=%h strobes=%0d, want 34/80000000/1", lat, tripBitmap, ns);
    end
  endtask

  task automatic test_reset_midscan_and_set_wins();
    int seen;
    clear_mem();
    mem[0] = 32'h8000_0000;
    csr_write(6'd4, 8'h00, 1'b0, 1'b1, 1'b1);
    gath.readoutValid = 1'b1;
    repeat (2) @(negedge sysClk);
    #2 sysReset_n = 1'b0;
    gath.readoutValid = 1'b0;
    #1;
    checks++;
    if (csr[31] !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b, want 0", csr[31]); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sysClk);
      if (scanDone || tripStrobe) seen++;
    end
    sysReset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge sysClk);
      if (scanDone || tripStrobe) seen++;
    end
    checks++;
    if (seen !== 0 || csr !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: strobes seen=%0d csr=%h, want 0/0", seen, csr);
    end
    csr_write(6'd4, 8'h00, 1'b1, 1'b1, 1'b0);
    GPIO_OUT = 32'hE000_0004;
    csrStrobe = 1'b1;
    gath.sysTimeoutStrobe = 1'b1;
    @(negedge sysClk);
    csrStrobe = 1'b0;
    GPIO_OUT = 32'h0;
    gath.sysTimeoutStrobe = 1'b0;
    checks++;
    if (tripLatched !== 1'b1 || csr[29] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: latched=%b timeout=%b, want 1/1", tripLatched, csr[29]);
    end
    csr_write(6'd4, 8'h00, 1'b1, 1'b1, 1'b1);
    checks++;
    if (tripLatched !== 1'b0 || csr[29] !== 1'b0) begin
      errors++;
      $display("FAIL clear_after: latched=%b timeout=%b, want 0/0", tripLatched, csr[29]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sysReset_n = 1'b0;
    csrStrobe = 1'b0;
    GPIO_OUT = 32'h0;
    gath.readoutValid = 1'b0;
    gath.sysTimeoutStrobe = 1'b0;
    gath.rxBitmap = 32'h0;
    clear_mem();
    @(negedge sysClk);
    test_reset();
    test_basic_mask();
    test_fault_and_clear();
    test_missing();
    test_timeout();
    test_zero_wrap_saturate();
    test_reset_midscan_and_set_wins();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
